toggle_cover_drain: RTL and testbench
=====================================

# toggle_cover_drain

Hardware-side collector for toggle-coverage hit vectors. It samples a per-cycle hit vector and keeps a sticky covered bitmap. Each newly covered bit's global cover index is emitted exactly once on a valid/ready stream, so coverage is drained to a host or trace sink instead of being reported point-by-point. It sits between a toggle-coverage group and the coverage export path. One instance serves one WIDTH-bit group located at COVER_INDEX in the global index space.

## Interface
- WIDTH, 32: number of toggle points in the group (1..64)
- COVER_INDEX, 0: global index of bit 0 of the group
- IDX_W, 32: width of emitted index
- gbl_clk  in  1  clock
- reset  in  1  reset, synchronous, active-low; clock gbl_clk
- hit  in  WIDTH  toggle hits this cycle; bit i set = point COVER_INDEX+i toggled
- clear  in  1  single-cycle pulse: start a new coverage epoch
- out_valid  out  1  out_index holds a newly covered index
- out_ready  in  1  sink accepts out_index this cycle
- out_index  out  IDX_W  global cover index, COVER_INDEX + bit position
- covered_cnt  out  $clog2(WIDTH+1)  number of covered bits in the current epoch
- all_covered  out  1  every bit of the group is covered

## Operation
- State:
  - covered[WIDTH-1:0]: sticky bitmap
  - pending[WIDTH-1:0]: covered bits not yet emitted
  - output register: out_valid, out_index
  - covered_cnt
- Each cycle when reset=1 and clear=0:
  - new = hit & ~covered
  - covered <= covered | hit
  - covered_cnt <= covered_cnt + popcount(new)
- Candidate set is cand = pending | new.
- Output register is free when out_valid=0 or (out_valid & out_ready).
- When the output register is free and cand != 0:
  - load the lowest set bit b of cand, with out_index = COVER_INDEX + b (zero-extended to IDX_W)
  - out_valid <= 1
  - pending <= cand with bit b cleared
- When the output register is free and cand == 0: out_valid <= 0 and pending <= cand.
- When the output register is not free: pending <= cand, and out_valid/out_index are held unchanged.
- Each index is emitted at most once per epoch, because a bit enters new only while it is uncovered. Repeated hits on a covered bit are ignored.
- Ordering: lowest index first among all outstanding bits. A later low-index hit can overtake an older pending high-index bit.
- all_covered = (covered == all ones), registered alongside covered.
- clear=1 (with reset=1):
  - covered, pending and covered_cnt go to 0; out_valid goes to 0 and an unaccepted index is dropped
  - hit sampled in the same cycle is discarded
  - out_ready is ignored that cycle

## Timing
- Reset (reset=0 at a gbl_clk edge) zeroes every register. While in reset: out_valid=0, out_index=0, covered_cnt=0, all_covered=0, and hit is ignored.
- Latency: a hit sampled at edge N with an idle output gives out_valid=1 in the cycle after edge N.
- Throughput: one index per cycle while out_ready=1. A full WIDTH-bit burst drains in WIDTH cycles.
- Handshake: a transfer occurs when out_valid & out_ready at the edge. While out_valid=1 and out_ready=0, out_index is stable. out_valid never drops without a transfer, except on clear or reset.
- covered_cnt and all_covered update at the same edge that hit is sampled; they do not wait for draining.
- Pending cannot overflow: it is bounded by WIDTH bits. No backpressure is applied to hit.
- Reset asserted mid-drain: outstanding indices are lost and the epoch restarts.

## Configuration
- TOGGLE_COVER_DRAIN_STALL_EN defined:
  - adds output port stall_cnt [31:0]
  - stall_cnt counts cycles with out_valid=1 and out_ready=0
  - saturates at 0xFFFFFFFF
  - cleared by reset and by clear
- TOGGLE_COVER_DRAIN_STALL_EN undefined: the port and counter do not exist, and behaviour is otherwise identical.

## Test plan
- Basic drain: COVER_INDEX=100, out_ready=1, hit=0x0000_0005 for one cycle. Required: out_index 100 then 102 on consecutive cycles, then out_valid=0, covered_cnt=2.
- Duplicate suppression: hit=0x1 for 5 consecutive cycles. Required: exactly one transfer (index COVER_INDEX), covered_cnt=1.
- Backpressure: out_ready=0 and hit=0xFFFF_FFFF for one cycle. Required: out_valid=1 with out_index=COVER_INDEX held stable for 10 cycles, covered_cnt=32, all_covered=1. Then out_ready=1: 32 transfers, indices ascending +0..+31, no gaps.
- Overtake: with out_ready=0, hit=0x8000_0000, then hit=0x2. Release out_ready. Required: order +31 (already loaded), +1.
- Clear: mid-drain with 5 indices pending, pulse clear together with hit=0x10. Required: next cycle out_valid=0, covered_cnt=0, bit 4 not covered. A subsequent hit=0x1 re-emits +0.
- Reset: reset=0 for 1 cycle mid-drain. Required: all outputs 0 next cycle. With STALL_EN, stall_cnt=0 after reset and counts exactly the held-valid cycles.

Source files
------------

// File: rtl/toggle_cover_drain.sv
// rtl/toggle_cover_drain.sv - toggle-coverage hit collector with once-per-epoch index drain
//
// Samples a per-cycle toggle hit vector into a sticky covered bitmap and emits
// the global cover index of every newly covered bit exactly once, lowest index
// first, on a valid/ready stream.
//
// Optional feature macro: TOGGLE_COVER_DRAIN_STALL_EN (adds stall_cnt).
//
// Ports:
//   gbl_clk      in   clock
//   reset        in   synchronous, active-low reset
//   hit          in   [WIDTH]  toggle hits this cycle (bit i = index COVER_INDEX+i)
//   clear        in   single-cycle pulse starting a new coverage epoch
//   out_valid    out  out_index holds a newly covered index
//   out_ready    in   sink accepts out_index this cycle
//   out_index    out  [IDX_W] global cover index
//   covered_cnt  out  [$clog2(WIDTH+1)] covered bits in the current epoch
//   all_covered  out  every bit of the group is covered
//   stall_cnt    out  [32] saturating count of out_valid & ~out_ready cycles
//                     (only with TOGGLE_COVER_DRAIN_STALL_EN)

module toggle_cover_drain #(
  parameter int WIDTH       = 32,
  parameter int COVER_INDEX = 0,
  parameter int IDX_W       = 32
) (
  input  logic                       gbl_clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           hit,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IDX_W-1:0]           out_index,
  output logic [$clog2(WIDTH+1)-1:0] covered_cnt,
  output logic                       all_covered
`ifdef TOGGLE_COVER_DRAIN_STALL_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] covered_q, covered_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_index_q, out_index_d;
  logic [CNT_W-1:0] covered_cnt_q, covered_cnt_d;
  logic             all_covered_q, all_covered_d;

  logic [WIDTH-1:0] new_bits;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] cand_low;
  logic [BIT_W-1:0] cand_pos;
  logic [CNT_W-1:0] new_pop;
  logic             out_free;

  always_comb begin
    new_bits = hit & ~covered_q;
    cand     = pending_q | new_bits;
    // Isolate the lowest set bit so it can be removed from the candidate set.
    cand_low = cand & (~cand + WIDTH'(1));
    out_free = ~out_valid_q | out_ready;

    // Scan high to low so the last match left standing is the lowest bit.
    cand_pos = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (cand[i]) cand_pos = BIT_W'(i);
    end

    new_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      new_pop = new_pop + CNT_W'(new_bits[i]);
    end

    covered_d     = covered_q | hit;
    covered_cnt_d = covered_cnt_q + new_pop;
    all_covered_d = &covered_d;

    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    pending_d   = cand;
    if (out_free) begin
      if (cand != '0) begin
        out_valid_d = 1'b1;
        out_index_d = IDX_W'(COVER_INDEX) + IDX_W'(cand_pos);
        pending_d   = cand & ~cand_low;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset || clear) begin
      // clear behaves like reset for the datapath: same-cycle hits and
      // any unaccepted index are dropped.
      covered_q     <= '0;
      pending_q     <= '0;
      out_valid_q   <= 1'b0;
      out_index_q   <= '0;
      covered_cnt_q <= '0;
      all_covered_q <= 1'b0;
    end else begin
      covered_q     <= covered_d;
      pending_q     <= pending_d;
      out_valid_q   <= out_valid_d;
      out_index_q   <= out_index_d;
      covered_cnt_q <= covered_cnt_d;
      all_covered_q <= all_covered_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_index   = out_index_q;
  assign covered_cnt = covered_cnt_q;
  assign all_covered = all_covered_q;

`ifdef TOGGLE_COVER_DRAIN_STALL_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge gbl_clk) begin
    if (!reset || clear) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_toggle_cover_drain.sv
// tb/tb_toggle_cover_drain.sv - directed self-checking bench for toggle_cover_drain

module tb_toggle_cover_drain;

  localparam int WIDTH = 32;
  localparam int CIDX  = 100;
  localparam int IDX_W = 32;

  logic              gbl_clk;
  logic              reset;
  logic [WIDTH-1:0]  hit;
  logic              clear;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_index;
  logic [5:0]        covered_cnt;
  logic              all_covered;
`ifdef TOGGLE_COVER_DRAIN_STALL_EN
  logic [31:0]       stall_cnt;
`endif

  int checks;
  int failures;

  toggle_cover_drain #(
    .WIDTH(WIDTH), .COVER_INDEX(CIDX), .IDX_W(IDX_W)
  ) dut (
    .gbl_clk    (gbl_clk),
    .reset      (reset),
    .hit        (hit),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .covered_cnt(covered_cnt),
    .all_covered(all_covered)
`ifdef TOGGLE_COVER_DRAIN_STALL_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial gbl_clk = 1'b0;
  always #5 gbl_clk = ~gbl_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one clock; outputs are observed and inputs changed 1ns after the edge.
  task automatic step();
    @(posedge gbl_clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    logic [IDX_W-1:0] first_idx;

    checks = 0;
    failures = 0;
    reset = 1'b0;
    hit = '0;
    clear = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_index", 64'(out_index), 64'd0);
    check("rst_cnt", 64'(covered_cnt), 64'd0);
    check("rst_all", 64'(all_covered), 64'd0);
    reset = 1'b1;

    // Basic drain: bits 0 and 2 emitted back to back, lowest first.
    out_ready = 1'b1;
    hit = 32'h0000_0005;
    step();
    hit = '0;
    check("basic_v0", 64'(out_valid), 64'd1);
    check("basic_i0", 64'(out_index), 64'd100);
    check("basic_cnt", 64'(covered_cnt), 64'd2);
    step();
    check("basic_v1", 64'(out_valid), 64'd1);
    check("basic_i1", 64'(out_index), 64'd102);
    step();
    check("basic_v2", 64'(out_valid), 64'd0);
    check("basic_cnt2", 64'(covered_cnt), 64'd2);

    // Duplicate suppression: bit 0 hit five cycles in a row.
    pulse_clear();
    check("clr_cnt", 64'(covered_cnt), 64'd0);
    n = 0;
    first_idx = '0;
    hit = 32'h1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) hit = '0;
      step();
      if (out_valid) begin
        if (n == 0) first_idx = out_index;
        n++;
      end
    end
    check("dup_xfers", 64'(n), 64'd1);
    check("dup_index", 64'(first_idx), 64'd100);
    check("dup_cnt", 64'(covered_cnt), 64'd1);

    // Backpressure: full burst held, then drained in order.
    pulse_clear();
    out_ready = 1'b0;
    hit = 32'hFFFF_FFFF;
    step();
    hit = '0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || out_index != IDX_W'(CIDX)) bad++;
      step();
    end
    check("bp_hold_bad", 64'(bad), 64'd0);
    check("bp_cnt", 64'(covered_cnt), 64'd32);
    check("bp_all", 64'(all_covered), 64'd1);
`ifdef TOGGLE_COVER_DRAIN_STALL_EN
    check("bp_stall", 64'(stall_cnt), 64'd10);
`endif
    out_ready = 1'b1;
    n = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        if (out_index != IDX_W'(CIDX + n)) bad++;
        n++;
      end
      step();
    end
    check("bp_xfers", 64'(n), 64'd32);
    check("bp_order_bad", 64'(bad), 64'd0);
    check("bp_idle", 64'(out_valid), 64'd0);
`ifdef TOGGLE_COVER_DRAIN_STALL_EN
    check("bp_stall_end", 64'(stall_cnt), 64'd10);
`endif

    // Overtake: loaded +31 goes first, later +1 beats nothing older.
    pulse_clear();
    out_ready = 1'b0;
    hit = 32'h8000_0000;
    step();
    hit = 32'h2;
    step();
    hit = '0;
    check("ovt_i0", 64'(out_index), 64'd131);
    out_ready = 1'b1;
    step();
    check("ovt_v1", 64'(out_valid), 64'd1);
    check("ovt_i1", 64'(out_index), 64'd101);
    step();
    check("ovt_v2", 64'(out_valid), 64'd0);

    // Clear mid-drain: same-cycle hit on bit 4 is discarded.
    out_ready = 1'b0;
    hit = 32'h3F;
    step();
    clear = 1'b1;
    hit = 32'h10;
    step();
    clear = 1'b0;
    hit = '0;
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_cnt2", 64'(covered_cnt), 64'd0);
    check("clr_all", 64'(all_covered), 64'd0);
    step();
    check("clr_quiet", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    hit = 32'h1;
    step();
    hit = 32'h10;
    check("clr_re_v", 64'(out_valid), 64'd1);
    check("clr_re_i", 64'(out_index), 64'd100);
    step();
    hit = '0;
    check("clr_b4_i", 64'(out_index), 64'd104);
    check("clr_b4_cnt", 64'(covered_cnt), 64'd2);

    // Reset mid-drain: outstanding indices lost.
    pulse_clear();
    out_ready = 1'b0;
    hit = 32'hF0;
    step();
    hit = '0;
    step();
    step();
    check("rmd_i", 64'(out_index), 64'd104);
`ifdef TOGGLE_COVER_DRAIN_STALL_EN
    check("rmd_stall", 64'(stall_cnt), 64'd2);
`endif
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rmd_valid", 64'(out_valid), 64'd0);
    check("rmd_index", 64'(out_index), 64'd0);
    check("rmd_cnt", 64'(covered_cnt), 64'd0);
    check("rmd_all", 64'(all_covered), 64'd0);
`ifdef TOGGLE_COVER_DRAIN_STALL_EN
    check("rmd_stall0", 64'(stall_cnt), 64'd0);
`endif
    out_ready = 1'b1;
    hit = 32'h8;
    step();
    hit = '0;
    check("rmd_new_i", 64'(out_index), 64'd103);
    check("rmd_new_cnt", 64'(covered_cnt), 64'd1);
    step();
    check("rmd_lost", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
